// File: rtl/audio_pkg.sv
// Shared audio types: sample and magnitude words, plus the envelope follower state encoding.
package audio_pkg;

   localparam int SAMPLE_WIDTH = 24;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
   typedef logic        [SAMPLE_WIDTH-2:0] mag_t;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } env_state_t;

endpackage

// File: rtl/env_ring_buf.sv
// Magnitude history for the moving-average window: one write port and an
// asynchronous read at the same address, so the oldest entry is visible before it is overwritten.
module env_ring_buf #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_WIDTH = 23
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/envelope_avg_unit.sv
// Envelope follower: rectifies signed samples and tracks a 2^AVG_LOG2-sample moving
// average of their magnitude for the cutoff frequency stage.
module envelope_avg_unit
   import audio_pkg::*;
#(
   parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH,
   parameter int AVG_LOG2     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   input  logic                    env_clr,
   output logic [SAMPLE_WIDTH-1:0] env_avg,
   output logic                    env_valid,
   output logic                    env_primed
);

   localparam int MAG_W  = SAMPLE_WIDTH - 1;
   localparam int SUM_W  = MAG_W + AVG_LOG2;
   localparam int WINDOW = 2 ** AVG_LOG2;

   localparam logic [AVG_LOG2-1:0] PTR_LAST  = '1;
   localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2+1)'(WINDOW);
   localparam logic [AVG_LOG2:0]   FILL_LAST = FILL_FULL - 1'b1;
   localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};

   env_state_t            state;
   logic [AVG_LOG2-1:0]   wr_ptr;
   logic [SUM_W-1:0]      sum;
   logic [AVG_LOG2:0]     fill_cnt;
   logic                  s1_valid;
   logic [MAG_W-1:0]      s1_mag;

   logic                    accept;
   logic                    stage2_fire;
   logic [SAMPLE_WIDTH-1:0] neg_sample;
   logic [MAG_W-1:0]        abs_mag;
   logic [MAG_W-1:0]        old_mag;
   logic                    ring_we;
   logic [MAG_W-1:0]        ring_wdata;
   logic [SUM_W-1:0]        new_sum;

   assign sample_ready = (state == RUN);
   assign accept       = sample_valid && sample_ready && !env_clr;
   assign stage2_fire  = s1_valid && !env_clr && (state == RUN);

   // The most negative sample has no positive twin, so it clamps to the largest magnitude.
   assign neg_sample = ~sample_in + 1'b1;
   always_comb begin
      abs_mag = sample_in[MAG_W-1:0];
      if (sample_in == MOST_NEG) begin
         abs_mag = '1;
      end else if (sample_in[SAMPLE_WIDTH-1]) begin
         abs_mag = neg_sample[MAG_W-1:0];
      end
   end

   assign ring_we    = (state == CLEAR) || stage2_fire;
   assign ring_wdata = (state == CLEAR) ? '0 : s1_mag;

   // Intermediate wrap is harmless: the true result always fits in SUM_W bits.
   assign new_sum = sum + SUM_W'(s1_mag) - SUM_W'(old_mag);

   env_ring_buf #(
      .DEPTH_LOG2 (AVG_LOG2),
      .DATA_WIDTH (MAG_W)
   ) u_ring (
      .clk     (clk),
      .wr_en   (ring_we),
      .addr    (wr_ptr),
      .wr_data (ring_wdata),
      .rd_data (old_mag)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= CLEAR;
         wr_ptr     <= '0;
         sum        <= '0;
         fill_cnt   <= '0;
         s1_valid   <= 1'b0;
         s1_mag     <= '0;
         env_avg    <= '0;
         env_valid  <= 1'b0;
         env_primed <= 1'b0;
      end else begin
         env_valid <= 1'b0;
         s1_valid  <= accept;
         if (accept) begin
            s1_mag <= abs_mag;
         end
         case (state)
            CLEAR: begin
               if (env_clr) begin
                  wr_ptr <= '0;
               end else begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (wr_ptr == PTR_LAST) begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (env_clr) begin
                  state      <= CLEAR;
                  wr_ptr     <= '0;
                  sum        <= '0;
                  fill_cnt   <= '0;
                  env_avg    <= '0;
                  env_primed <= 1'b0;
               end else if (stage2_fire) begin
                  wr_ptr    <= wr_ptr + 1'b1;
                  sum       <= new_sum;
                  env_avg   <= {1'b0, new_sum[SUM_W-1:AVG_LOG2]};
                  env_valid <= 1'b1;
                  if (fill_cnt != FILL_FULL) begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
                  if (fill_cnt == FILL_LAST) begin
                     env_primed <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
